wb_write_arbiter: RTL and testbench
===================================

Name: wb_write_arbiter

Overview:
- Writeback-side producer for the integer register file's single write port; drives the write-enable, destination-address and write-data inputs of that port.
- Merges two result streams into that one port:
  - in-order pipeline retire channel (pipe_*);
  - long-latency channel (ll_*: mul/div, misaligned-load completion).
- Long-latency results are buffered in a small FIFO. Anti-starvation aging guarantees the FIFO eventually drains under continuous pipeline traffic.

Parameters:
- XLEN, 64, data width of register write data.
- FIFO_DEPTH, 2, long-latency buffer entries (power of two, >=2).
- STARVE_LIMIT, 4, consecutive pipeline grants allowed while the FIFO is non-empty before the FIFO is forced to win.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pipe_valid  in  1  pipeline result valid.
- pipe_ready  out  1  pipeline result accepted this cycle if valid.
- pipe_dest  in  5  pipeline destination register.
- pipe_data  in  XLEN  pipeline result.
- ll_valid  in  1  long-latency result valid.
- ll_ready  out  1  FIFO can accept.
- ll_dest  in  5  long-latency destination register.
- ll_data  in  XLEN  long-latency result.
- reg_write_enable  out  1  register file write strobe.
- reg_dest_addr  out  5  register file write address.
- reg_write_data  out  XLEN  register file write data.
- ll_pending  out  1  FIFO non-empty.

Behaviour:
- Reset (async, rst=1): FIFO emptied (rd/wr pointers, count = 0), starve_cnt = 0, reg_write_enable = 0, reg_dest_addr = 0, reg_write_data = 0. Entries in flight are dropped; no partial write escapes.
- All outputs except pipe_ready and ll_ready are registered. pipe_ready and ll_ready are combinational from registered state only; neither depends on pipe_valid or ll_valid.
- Handshake: a transfer occurs on a cycle where valid && ready at the rising clk edge. Producers hold dest/data stable while valid && !ready.
- FIFO:
  - ll_ready = (count != FIFO_DEPTH). While full, ll_ready = 0 even in a cycle that pops; there is no same-cycle full push+pop.
  - Push and pop in the same cycle while not full: count unchanged, pointers wrap modulo FIFO_DEPTH.
  - No bypass: a pushed entry is poppable no earlier than the next cycle.
  - ll_pending = (count != 0).
- Arbitration, each cycle:
  - force = ll_pending && (starve_cnt == STARVE_LIMIT).
  - pipe_ready = !force.
  - pipe_grant = pipe_valid && pipe_ready.
  - ll_grant (FIFO pop) = ll_pending && !pipe_grant.
  - At most one grant per cycle.
- starve_cnt:
  - 0 when the FIFO is empty.
  - On pipe_grant with ll_pending = 1: +1, saturating at STARVE_LIMIT.
  - On ll_grant: cleared to 0.
- Output register, next edge:
  - reg_write_enable <= grant && (granted dest != 0).
  - reg_dest_addr / reg_write_data <= granted entry when any grant occurs; hold their value otherwise.
  - A dest of x0 is accepted and consumed (popped or acked) but never writes.
- Latency:
  - Pipeline: accepted at edge N, write strobe high for the cycle after N; the register file commits at edge N+1.
  - Long-latency: pushed at edge N, earliest pop at edge N+1, strobe the cycle after that.
- Ordering:
  - Within each channel, results are written in acceptance order.
  - Across channels, order follows grants. WAW hazards between channels are the issuer's responsibility; the arbiter does not compare dests.
- Throughput: one register write per cycle maximum. Idle cycles have strobe 0.
- Reset asserted mid-transfer: the outputs clear immediately (asynchronously); the transfer is lost.

Test Plan:
- Reset then idle → all outputs 0, pipe_ready=1, ll_ready=1, ll_pending=0 for 10 cycles.
- Single pipe write, pipe_dest=5, pipe_data=0xDEAD_BEEF_0000_0001 at edge N → strobe=1, addr=5, data=0xDEAD_BEEF_0000_0001 during cycle N+1 only.
- ll push dest=7, data=0x42 with pipe idle → ll_pending=1 after the push edge; strobe with addr 7, data 0x42 two cycles after the push; ll_pending returns to 0.
- Starvation, STARVE_LIMIT=4:
  - Stimulus: one ll entry (dest 9) queued; pipe_valid held high with dests 1,2,3,… every cycle.
  - Response: exactly 4 pipe writes, then pipe_ready=0 for one cycle and reg 9 is written; pipe then resumes; starve_cnt back to 0.
- FIFO full: 2 ll pushes with pipe saturating (pipe ready, pipe_valid=1) → ll_ready=0 while count=2, stays 0 during the first pop cycle, and a third ll_valid is held until ll_ready=1. No entry lost or duplicated; write order matches push order.
- x0 and mid-operation reset:
  - pipe_dest=0, data=0xFFFF → handshake completes, strobe stays 0.
  - Then 2 ll entries queued and rst pulsed between clock edges → outputs 0 immediately, ll_pending=0, neither entry ever written.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: merges pipeline retire and
// long-latency results, with a small FIFO and anti-starvation aging.
module wb_write_arbiter #(
   parameter int XLEN         = 64,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pipe_valid,
   output logic            pipe_ready,
   input  logic [4:0]      pipe_dest,
   input  logic [XLEN-1:0] pipe_data,
   input  logic            ll_valid,
   output logic            ll_ready,
   input  logic [4:0]      ll_dest,
   input  logic [XLEN-1:0] ll_data,
   output logic            reg_write_enable,
   output logic [4:0]      reg_dest_addr,
   output logic [XLEN-1:0] reg_write_data,
   output logic            ll_pending
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
   localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

   logic [4:0]      dest_mem_q [FIFO_DEPTH];
   logic [4:0]      dest_mem_d [FIFO_DEPTH];
   logic [XLEN-1:0] data_mem_q [FIFO_DEPTH];
   logic [XLEN-1:0] data_mem_d [FIFO_DEPTH];

   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic            pending_q, pending_d;
   logic            we_q, we_d;
   logic [4:0]      addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;

   logic            force_ll;
   logic            pipe_grant;
   logic            ll_grant;
   logic            push;
   logic [4:0]      head_dest;
   logic [XLEN-1:0] head_data;

   // Ready signals derive only from registered state.
   always_comb begin
      force_ll   = pending_q && (starve_q == SLIM);
      pipe_ready = !force_ll;
      ll_ready   = (count_q != FULL);
   end

   // Grant selection, FIFO bookkeeping and next output register values.
   always_comb begin
      pipe_grant = pipe_valid && pipe_ready;
      ll_grant   = pending_q && !pipe_grant;
      push       = ll_valid && ll_ready;
      head_dest  = dest_mem_q[rd_ptr_q];
      head_data  = data_mem_q[rd_ptr_q];

      dest_mem_d = dest_mem_q;
      data_mem_d = data_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;

      if (push) begin
         dest_mem_d[wr_ptr_q] = ll_dest;
         data_mem_d[wr_ptr_q] = ll_data;
         wr_ptr_d             = wr_ptr_q + AW'(1);
      end
      if (ll_grant) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      count_d   = count_q + CW'(push) - CW'(ll_grant);
      pending_d = (count_d != '0);

      starve_d = starve_q;
      if (ll_grant) begin
         starve_d = '0;
      end else if (pipe_grant && pending_q && (starve_q != SLIM)) begin
         starve_d = starve_q + SW'(1);
      end

      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (pipe_grant) begin
         we_d    = (pipe_dest != 5'd0);
         addr_d  = pipe_dest;
         wdata_d = pipe_data;
      end else if (ll_grant) begin
         we_d    = (head_dest != 5'd0);
         addr_d  = head_dest;
         wdata_d = head_data;
      end
   end

   // All state, cleared asynchronously so no partial write escapes reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            dest_mem_q[i] <= '0;
            data_mem_q[i] <= '0;
         end
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         starve_q  <= '0;
         pending_q <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         dest_mem_q <= dest_mem_d;
         data_mem_q <= data_mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         starve_q   <= starve_d;
         pending_q  <= pending_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
      end
   end

   assign reg_write_enable = we_q;
   assign reg_dest_addr    = addr_q;
   assign reg_write_data   = wdata_q;
   assign ll_pending       = pending_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_wb_write_arbiter;

   localparam int XLEN  = 64;
   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   typedef struct {
      logic [4:0]      dest;
      logic [XLEN-1:0] data;
   } wb_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            pipe_valid;
   logic            pipe_ready;
   logic [4:0]      pipe_dest;
   logic [XLEN-1:0] pipe_data;
   logic            ll_valid;
   logic            ll_ready;
   logic [4:0]      ll_dest;
   logic [XLEN-1:0] ll_data;
   logic            reg_write_enable;
   logic [4:0]      reg_dest_addr;
   logic [XLEN-1:0] reg_write_data;
   logic            ll_pending;

   int errors = 0;
   int checks = 0;

   wb_t             llq[$];
   int              starve;
   logic            exp_we;
   logic [4:0]      exp_addr;
   logic [XLEN-1:0] exp_data;
   logic            last_pg, last_push;
   logic            obs_pr, obs_lr;

   wb_write_arbiter #(
      .XLEN(XLEN), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .rst(rst),
      .pipe_valid(pipe_valid), .pipe_ready(pipe_ready),
      .pipe_dest(pipe_dest), .pipe_data(pipe_data),
      .ll_valid(ll_valid), .ll_ready(ll_ready),
      .ll_dest(ll_dest), .ll_data(ll_data),
      .reg_write_enable(reg_write_enable),
      .reg_dest_addr(reg_dest_addr),
      .reg_write_data(reg_write_data),
      .ll_pending(ll_pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: check readies, advance the model, check registered outputs.
   task automatic step();
      bit  pend, pr, lr, pg, lg, push;
      wb_t h;
      #1;
      pend   = (llq.size() != 0);
      pr     = !(pend && (starve == LIMIT));
      lr     = (llq.size() < DEPTH);
      obs_pr = pipe_ready;
      obs_lr = ll_ready;
      chk("pipe_ready", 64'(pipe_ready), 64'(pr));
      chk("ll_ready", 64'(ll_ready), 64'(lr));
      pg   = pipe_valid && pr;
      lg   = pend && !pg;
      push = ll_valid && lr;
      if (pg) begin
         exp_we   = (pipe_dest != 0);
         exp_addr = pipe_dest;
         exp_data = pipe_data;
      end else if (lg) begin
         h        = llq.pop_front();
         exp_we   = (h.dest != 0);
         exp_addr = h.dest;
         exp_data = h.data;
      end else begin
         exp_we = 1'b0;
      end
      if (lg) starve = 0;
      else if (pg && pend && starve < LIMIT) starve++;
      if (push) begin
         h.dest = ll_dest;
         h.data = ll_data;
         llq.push_back(h);
      end
      last_pg   = pg;
      last_push = push;
      @(posedge clk);
      #1;
      chk("we", 64'(reg_write_enable), 64'(exp_we));
      chk("addr", 64'(reg_dest_addr), 64'(exp_addr));
      chk("data", reg_write_data, exp_data);
      chk("pending", 64'(ll_pending), 64'(llq.size() != 0));
      @(negedge clk);
   endtask

   initial begin
      int k;
      bit stalled;
      logic [4:0] d;
      rst        = 1'b1;
      pipe_valid = 1'b0;
      pipe_dest  = '0;
      pipe_data  = '0;
      ll_valid   = 1'b0;
      ll_dest    = '0;
      ll_data    = '0;
      starve     = 0;
      exp_we     = 1'b0;
      exp_addr   = '0;
      exp_data   = '0;
      last_pg    = 1'b0;
      last_push  = 1'b0;
      #12;
      @(negedge clk);
      chk("rst_we", 64'(reg_write_enable), 64'd0);
      chk("rst_pending", 64'(ll_pending), 64'd0);
      rst = 1'b0;

      // Reset then idle.
      for (int i = 0; i < 10; i++) step();
      chk("idle_pipe_ready", 64'(pipe_ready), 64'd1);
      chk("idle_ll_ready", 64'(ll_ready), 64'd1);

      // Single pipeline write.
      pipe_valid = 1'b1;
      pipe_dest  = 5'd5;
      pipe_data  = 64'hDEAD_BEEF_0000_0001;
      step();
      pipe_valid = 1'b0;
      chk("pipe_we", 64'(reg_write_enable), 64'd1);
      chk("pipe_addr", 64'(reg_dest_addr), 64'd5);
      chk("pipe_data", reg_write_data, 64'hDEAD_BEEF_0000_0001);
      step();
      chk("pipe_we_once", 64'(reg_write_enable), 64'd0);

      // Long-latency single push, pipe idle.
      ll_valid = 1'b1;
      ll_dest  = 5'd7;
      ll_data  = 64'h42;
      step();
      ll_valid = 1'b0;
      chk("ll_pend_set", 64'(ll_pending), 64'd1);
      chk("ll_no_bypass", 64'(reg_write_enable), 64'd0);
      step();
      chk("ll_we", 64'(reg_write_enable), 64'd1);
      chk("ll_addr", 64'(reg_dest_addr), 64'd7);
      chk("ll_data", reg_write_data, 64'h42);
      chk("ll_pend_clr", 64'(ll_pending), 64'd0);

      // Starvation: one ll entry against continuous pipe traffic.
      d          = 5'd1;
      pipe_valid = 1'b1;
      pipe_dest  = d;
      pipe_data  = {$urandom, $urandom};
      ll_valid   = 1'b1;
      ll_dest    = 5'd9;
      ll_data    = {$urandom, $urandom};
      step();
      ll_valid = 1'b0;
      d        = d + 5'd1;
      pipe_dest = d;
      k        = 0;
      stalled  = 1'b0;
      for (int i = 0; i < 12 && !stalled; i++) begin
         bit pre;
         pre = ll_pending;
         step();
         if (!obs_pr) stalled = 1'b1;
         else if (pre) k++;
         if (last_pg) begin
            d         = d + 5'd1;
            pipe_dest = d;
            pipe_data = {$urandom, $urandom};
         end
      end
      chk("starve_stalled", 64'(stalled), 64'd1);
      chk("starve_grants", 64'(k), 64'(LIMIT));
      chk("starve_addr", 64'(reg_dest_addr), 64'd9);
      step();
      chk("starve_resume", 64'(obs_pr), 64'd1);
      pipe_valid = 1'b0;
      step();

      // FIFO full under saturating pipe traffic.
      pipe_valid = 1'b1;
      pipe_dest  = 5'd10;
      ll_valid   = 1'b1;
      ll_dest    = 5'd11;
      ll_data    = 64'h1111;
      step();
      pipe_dest = 5'd12;
      ll_dest   = 5'd13;
      ll_data   = 64'h1313;
      step();
      ll_dest  = 5'd14;
      ll_data  = 64'h1414;
      stalled  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         pipe_dest = 5'($urandom_range(15, 31));
         pipe_data = {$urandom, $urandom};
         step();
         if (!obs_pr && !stalled) begin
            stalled = 1'b1;
            chk("full_pop_ll_ready", 64'(obs_lr), 64'd0);
         end
         if (last_push) break;
      end
      chk("ll3_accepted", 64'(last_push), 64'd1);
      pipe_valid = 1'b0;
      ll_valid   = 1'b0;
      for (int i = 0; i < 4; i++) step();

      // x0 write and reset with entries queued.
      pipe_valid = 1'b1;
      pipe_dest  = 5'd0;
      pipe_data  = 64'hFFFF;
      step();
      chk("x0_acked", 64'(last_pg), 64'd1);
      chk("x0_no_we", 64'(reg_write_enable), 64'd0);
      pipe_dest = 5'd3;
      pipe_data = {$urandom, $urandom};
      ll_valid  = 1'b1;
      ll_dest   = 5'd20;
      ll_data   = 64'h2020;
      step();
      pipe_dest = 5'd4;
      ll_dest   = 5'd21;
      ll_data   = 64'h2121;
      step();
      pipe_valid = 1'b0;
      ll_valid   = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_we", 64'(reg_write_enable), 64'd0);
      chk("mid_rst_addr", 64'(reg_dest_addr), 64'd0);
      chk("mid_rst_data", reg_write_data, 64'd0);
      chk("mid_rst_pending", 64'(ll_pending), 64'd0);
      chk("mid_rst_ll_ready", 64'(ll_ready), 64'd1);
      llq.delete();
      starve   = 0;
      exp_we   = 1'b0;
      exp_addr = '0;
      exp_data = '0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) step();

      // Random traffic; producers hold while not accepted.
      last_pg   = 1'b1;
      last_push = 1'b1;
      for (int c = 0; c < 400; c++) begin
         if (!pipe_valid || last_pg) begin
            pipe_valid = ($urandom_range(0, 3) != 0);
            pipe_dest  = 5'($urandom_range(0, 31));
            pipe_data  = {$urandom, $urandom};
         end
         if (!ll_valid || last_push) begin
            ll_valid = ($urandom_range(0, 2) == 0);
            ll_dest  = 5'($urandom_range(0, 31));
            ll_data  = {$urandom, $urandom};
         end
         step();
      end
      pipe_valid = 1'b0;
      ll_valid   = 1'b0;
      for (int i = 0; i < 4; i++) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
